writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final Y86-64 pipeline stage: the M->W pipeline register and the register-file write side.
//  Presents W_valE/W_dstE and W_valM/W_dstM to the decode/register-file block (written on negedge clk)
//  and to decode's forwarding network.
//  Owns the architectural program status, the halt latch and the retired-instruction/cycle counters.
// PARAMETERS
//  DATA_W  64  width of valE/valM datapath
//  CNT_W   64  width of retire and cycle counters
// PORTS
//  clk         in   1       rising-edge clock; sole clock
//  reset       in   1       synchronous, active-high reset
//  m_stat      in   4       status from memory stage (includes dmem error)
//  M_icode     in   4       icode in M register
//  M_valE      in   DATA_W  ALU result in M register
//  m_valM      in   DATA_W  data-memory read value
//  M_dstE      in   4       E-port destination register (F = none)
//  M_dstM      in   4       M-port destination register (F = none)
//  W_stall     in   1       hold W register
//  W_bubble    in   1       load bubble into W register
//  W_stat      out  4       stat in W register
//  W_icode     out  4       icode in W register
//  W_valE      out  DATA_W  value for E write port
//  W_valM      out  DATA_W  value for M write port
//  W_dstE      out  4       E write-port register; forced F unless W_stat==AOK
//  W_dstM      out  4       M write-port register; forced F unless W_stat==AOK
//  prog_stat   out  4       architectural status (AOK/HLT/ADR/INS)
//  halted      out  1       sticky: a non-AOK instruction has reached W
//  retired     out  CNT_W   count of AOK, non-bubble instructions loaded into W
//  cycles      out  CNT_W   clock cycles since reset while not halted
// BEHAVIOUR
//  - Stat codes: AOK=1, HLT=2, ADR=3, INS=4, BUB=0. icode NOP=1. RNONE=F.
//  - Reset (sync): W register := bubble (stat BUB, icode NOP, valE=valM=0, dstE=dstM=F, valid=0);
//    prog_stat=AOK, halted=0, retired=0, cycles=0.
//  - Each posedge, priority: reset > halted (freeze) > W_stall (hold) > W_bubble (load bubble) > load M.
//  - Load: W fields := {m_stat,M_icode,M_valE,m_valM,M_dstE,M_dstM}, valid=1. One-cycle latency M->W.
//  - W_stall and W_bubble together: stall wins, register holds.
//  - Write gating (combinational): W_dstE/W_dstM output = stored dst when W_stat==AOK, else F.
//    A faulting or halting instruction never writes the register file.
//  - prog_stat (combinational): AOK if W_stat==BUB, else W_stat; once halted, the frozen W_stat.
//  - halted: set on the posedge after W holds stat in {HLT,ADR,INS}; cleared only by reset.
//    After halt the W register, counters and outputs are frozen regardless of stall/bubble/M inputs.
//  - retired: +1 on each load of a valid entry with m_stat==AOK and M_icode!=NOP; not on stall,
//    bubble or halted cycles. Wraps modulo 2^CNT_W.
//  - cycles: +1 every non-reset cycle while halted==0; wraps modulo 2^CNT_W.
//  - Reset mid-stall or mid-halt: reset wins; all state returns to reset values next edge.
//  - dstE==dstM, both !=F, both valid: both presented; the register file gives the M port priority
//    (popq %rsp semantics).
// STRUCTURE
//  - Shared package y86_pkg: stat codes (S_AOK,S_HLT,S_ADR,S_INS,S_BUB), icode constants
//    (I_HALT..I_POPQ), RNONE, pipe-register field struct/width constants.
//  - One sub-module: pipe_reg #(W, BUBBLE_VAL): generic stage register with stall/bubble/reset,
//    reused for F/D/E/M registers.
//  - Counters, halt latch and write gating live in writeback_stage.
// TESTING
//  1 Reset: hold reset 2 cycles -> W_stat=0, W_dstE=W_dstM=F, prog_stat=1, halted=0, retired=cycles=0.
//  2 Load irmovq: m_stat=1, M_icode=3, M_valE=0x2A, M_dstE=0 -> next cycle W_valE=0x2A,
//    W_dstE=0, retired=1.
//  3 Stall: load valid entry, then W_stall=1 with W_bubble=1 for 3 cycles and new M inputs ->
//    W fields unchanged, retired unchanged, cycles +3.
//  4 Bubble: W_bubble=1 -> W_icode=1, W_dstE=W_dstM=F, prog_stat=1, retired unchanged.
//  5 Fault: m_stat=3 (ADR), M_dstM=5 -> W_dstM output F, prog_stat=3, halted=1 next edge;
//    later loads ignored, cycles frozen.
//  6 Wrap: CNT_W=4, run 16 AOK loads -> retired wraps to 0; then reset mid-run -> all counters 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, instruction codes, register ids
// and the control-field layout used by the pipeline registers.
package y86_pkg;

    localparam logic [3:0] S_BUB = 4'h0;
    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    // Non-datapath part of the W register; the two data words are appended after it.
    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
        logic       valid;
    } w_ctrl_t;

    localparam int W_CTRL_W = $bits(w_ctrl_t);

    localparam w_ctrl_t W_CTRL_BUBBLE = '{
        stat:  S_BUB,
        icode: I_NOP,
        dst_e: RNONE,
        dst_m: RNONE,
        valid: 1'b0
    };

    function automatic logic is_fault(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline stage register. Priority on each edge: reset > stall (hold)
// > bubble (load BUBBLE_VAL) > load d. Stall together with bubble holds.
module pipe_reg #(
    parameter int           W          = 8,
    parameter logic [W-1:0] BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] reg_d;
    logic [W-1:0] reg_q;

    always_comb begin
        reg_d = reg_q;
        if (!stall) begin
            reg_d = bubble ? BUBBLE_VAL : d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q <= BUBBLE_VAL;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: M->W pipeline register, register-file write gating,
// architectural status, sticky halt latch and retire/cycle counters.
module writeback_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [3:0]        prog_stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  cycles
);

    localparam int W_W = W_CTRL_W + 2 * DATA_W;
    localparam logic [W_W-1:0] W_BUBBLE = {W_CTRL_BUBBLE, {(2 * DATA_W){1'b0}}};

    w_ctrl_t          m_ctrl;
    w_ctrl_t          w_ctrl;
    logic [W_W-1:0]   w_in;
    logic [W_W-1:0]   w_out;
    logic             freeze;
    logic             w_hold;
    logic             load;

    logic             halted_d, halted_q;
    logic [CNT_W-1:0] retired_d, retired_q;
    logic [CNT_W-1:0] cycles_d, cycles_q;

    assign m_ctrl = '{
        stat:  m_stat,
        icode: M_icode,
        dst_e: M_dstE,
        dst_m: M_dstM,
        valid: 1'b1
    };
    assign w_in = {m_ctrl, M_valE, m_valM};

    // A faulting entry in W freezes the register at once, so the status it
    // reports stays visible after the halt latch sets on the following edge.
    assign freeze = halted_q | is_fault(w_ctrl.stat);
    assign w_hold = W_stall | freeze;
    assign load   = !w_hold && !W_bubble;

    pipe_reg #(
        .W          (W_W),
        .BUBBLE_VAL (W_BUBBLE)
    ) u_w_reg (
        .clk    (clk),
        .reset  (reset),
        .stall  (w_hold),
        .bubble (W_bubble),
        .d      (w_in),
        .q      (w_out)
    );

    assign {w_ctrl, W_valE, W_valM} = w_out;

    always_comb begin
        halted_d  = freeze;
        retired_d = retired_q;
        cycles_d  = cycles_q;
        if (load && (m_stat == S_AOK) && (M_icode != I_NOP)) begin
            retired_d = retired_q + CNT_W'(1);
        end
        if (!halted_q) begin
            cycles_d = cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q  <= 1'b0;
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            halted_q  <= halted_d;
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    // Only a valid AOK instruction may write the register file.
    always_comb begin
        W_stat    = w_ctrl.stat;
        W_icode   = w_ctrl.icode;
        W_dstE    = RNONE;
        W_dstM    = RNONE;
        prog_stat = (w_ctrl.stat == S_BUB) ? S_AOK : w_ctrl.stat;
        if (w_ctrl.valid && (w_ctrl.stat == S_AOK)) begin
            W_dstE = w_ctrl.dst_e;
            W_dstM = w_ctrl.dst_m;
        end
    end

    assign halted  = halted_q;
    assign retired = retired_q;
    assign cycles  = cycles_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against an instruction-level reference model.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  m_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;

    logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, prog_stat;
    logic [63:0] W_valE, W_valM, retired, cycles;
    logic        halted;

    logic [3:0]  w4_stat, w4_icode, w4_dstE, w4_dstM, w4_prog;
    logic [63:0] w4_valE, w4_valM;
    logic [3:0]  w4_retired, w4_cycles;
    logic        w4_halted;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_stage #(.DATA_W(64), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .m_stat(m_stat), .M_icode(M_icode),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .prog_stat(prog_stat),
        .halted(halted), .retired(retired), .cycles(cycles)
    );

    // Narrow-counter copy sharing every input, used to observe counter wrap.
    writeback_stage #(.DATA_W(64), .CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .m_stat(m_stat), .M_icode(M_icode),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(w4_stat), .W_icode(w4_icode), .W_valE(w4_valE), .W_valM(w4_valM),
        .W_dstE(w4_dstE), .W_dstM(w4_dstM), .prog_stat(w4_prog),
        .halted(w4_halted), .retired(w4_retired), .cycles(w4_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic bub,
                         input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        reset    = rst;
        W_stall  = stl;
        W_bubble = bub;
        m_stat   = st;
        M_icode  = ic;
        M_valE   = ve;
        m_valM   = vm;
        M_dstE   = de;
        M_dstM   = dm;
    endtask

    // Inputs are applied 1 time unit after an edge; outputs sampled 1 unit after the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stl, bub;
        logic [3:0]  st, ic;
        logic [63:0] ve, vm;
        logic [3:0]  de, dm;
        logic [3:0]  e_stat, e_icode;
        logic [63:0] e_vale;
        logic [3:0]  e_dste, e_dstm, e_prog;
        logic        e_halt;
        logic [63:0] e_ret, e_cyc;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic bub,
        input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
        input logic [3:0] e_stat, input logic [3:0] e_icode, input logic [63:0] e_vale,
        input logic [3:0] e_dste, input logic [3:0] e_dstm, input logic [3:0] e_prog,
        input logic e_halt, input logic [63:0] e_ret, input logic [63:0] e_cyc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.bub = bub; v.st = st; v.ic = ic;
        v.ve = ve; v.vm = vm; v.de = de; v.dm = dm;
        v.e_stat = e_stat; v.e_icode = e_icode; v.e_vale = e_vale;
        v.e_dste = e_dste; v.e_dstm = e_dstm; v.e_prog = e_prog;
        v.e_halt = e_halt; v.e_ret = e_ret; v.e_cyc = e_cyc;
        return v;
    endfunction

    // Reference model: W contents as the architecture sees them, plus counters.
    typedef struct {
        logic [3:0]  stat, icode, dste, dstm;
        logic [63:0] vale, valm;
    } wrec_t;

    wrec_t       mw;
    logic        m_halt;
    logic [63:0] m_ret, m_cyc;

    function automatic wrec_t bubble_rec();
        wrec_t r;
        r.stat = 4'h0; r.icode = 4'h1; r.dste = 4'hF; r.dstm = 4'hF;
        r.vale = '0;   r.valm = '0;
        return r;
    endfunction

    task automatic model_reset();
        mw = bubble_rec(); m_halt = 1'b0; m_ret = '0; m_cyc = '0;
    endtask

    // One clock edge of the model, using the inputs currently driven.
    task automatic model_edge();
        logic stopped;
        if (reset) begin
            model_reset();
        end else begin
            stopped = m_halt || (mw.stat inside {4'h2, 4'h3, 4'h4});
            if (!m_halt) m_cyc = m_cyc + 1;
            if (stopped) begin
                m_halt = 1'b1;
            end else if (W_stall) begin
                // instruction stays in W
            end else if (W_bubble) begin
                mw = bubble_rec();
            end else begin
                mw.stat = m_stat; mw.icode = M_icode; mw.vale = M_valE;
                mw.valm = m_valM; mw.dste = M_dstE; mw.dstm = M_dstM;
                if (m_stat == 4'h1 && M_icode != 4'h1) m_ret = m_ret + 1;
            end
        end
    endtask

    task automatic model_compare();
        logic ok_write;
        ok_write = (mw.stat == 4'h1);
        chk("rnd_stat",    W_stat,    mw.stat);
        chk("rnd_icode",   W_icode,   mw.icode);
        chk("rnd_valE",    W_valE,    mw.vale);
        chk("rnd_valM",    W_valM,    mw.valm);
        chk("rnd_dstE",    W_dstE,    ok_write ? mw.dste : 4'hF);
        chk("rnd_dstM",    W_dstM,    ok_write ? mw.dstm : 4'hF);
        chk("rnd_prog",    prog_stat, (mw.stat == 4'h0) ? 4'h1 : mw.stat);
        chk("rnd_halted",  halted,    m_halt);
        chk("rnd_retired", retired,   m_ret);
        chk("rnd_cycles",  cycles,    m_cyc);
        chk("rnd_ret4",    w4_retired, m_ret[3:0]);
        chk("rnd_cyc4",    w4_cycles,  m_cyc[3:0]);
    endtask

    vec_t tbl[13];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);

        //           rst  stl  bub  st   ic   valE     valM  dE   dM    stat icode valE     dE   dM   prog halt ret cyc
        tbl[0]  = mk(1'b1,1'b0,1'b0,4'h1,4'h3,64'h11,  64'h0,4'h1,4'hF, 4'h0,4'h1, 64'h0,   4'hF,4'hF,4'h1,1'b0,0, 0);
        tbl[1]  = mk(1'b1,1'b0,1'b0,4'h1,4'h3,64'h11,  64'h0,4'h1,4'hF, 4'h0,4'h1, 64'h0,   4'hF,4'hF,4'h1,1'b0,0, 0);
        tbl[2]  = mk(1'b0,1'b0,1'b0,4'h1,4'h3,64'h2A,  64'h0,4'h0,4'hF, 4'h1,4'h3, 64'h2A,  4'h0,4'hF,4'h1,1'b0,1, 1);
        tbl[3]  = mk(1'b0,1'b0,1'b1,4'h1,4'h6,64'h99,  64'h0,4'h3,4'hF, 4'h0,4'h1, 64'h0,   4'hF,4'hF,4'h1,1'b0,1, 2);
        tbl[4]  = mk(1'b0,1'b0,1'b0,4'h1,4'h6,64'h7,   64'h0,4'h3,4'hF, 4'h1,4'h6, 64'h7,   4'h3,4'hF,4'h1,1'b0,2, 3);
        tbl[5]  = mk(1'b0,1'b0,1'b0,4'h1,4'h1,64'h0,   64'h0,4'hF,4'hF, 4'h1,4'h1, 64'h0,   4'hF,4'hF,4'h1,1'b0,2, 4);
        tbl[6]  = mk(1'b0,1'b0,1'b0,4'h1,4'hB,64'h8,   64'h9,4'h4,4'h4, 4'h1,4'hB, 64'h8,   4'h4,4'h4,4'h1,1'b0,3, 5);
        tbl[7]  = mk(1'b0,1'b1,1'b1,4'h1,4'h6,64'h55,  64'h0,4'h2,4'hF, 4'h1,4'hB, 64'h8,   4'h4,4'h4,4'h1,1'b0,3, 6);
        tbl[8]  = mk(1'b0,1'b0,1'b0,4'h3,4'h5,64'h100, 64'h0,4'hF,4'h5, 4'h3,4'h5, 64'h100, 4'hF,4'hF,4'h3,1'b0,3, 7);
        tbl[9]  = mk(1'b0,1'b0,1'b0,4'h1,4'h6,64'h77,  64'h0,4'h2,4'hF, 4'h3,4'h5, 64'h100, 4'hF,4'hF,4'h3,1'b1,3, 8);
        tbl[10] = mk(1'b0,1'b0,1'b0,4'h1,4'h3,64'h78,  64'h0,4'h2,4'hF, 4'h3,4'h5, 64'h100, 4'hF,4'hF,4'h3,1'b1,3, 8);
        tbl[11] = mk(1'b0,1'b0,1'b1,4'h1,4'h3,64'h79,  64'h0,4'h2,4'hF, 4'h3,4'h5, 64'h100, 4'hF,4'hF,4'h3,1'b1,3, 8);
        tbl[12] = mk(1'b1,1'b1,1'b0,4'h1,4'h3,64'h7A,  64'h0,4'h2,4'hF, 4'h0,4'h1, 64'h0,   4'hF,4'hF,4'h1,1'b0,0, 0);

        #1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].stl, tbl[i].bub, tbl[i].st, tbl[i].ic,
                  tbl[i].ve, tbl[i].vm, tbl[i].de, tbl[i].dm);
            tick();
            chk($sformatf("vec%0d_stat", i),    W_stat,    tbl[i].e_stat);
            chk($sformatf("vec%0d_icode", i),   W_icode,   tbl[i].e_icode);
            chk($sformatf("vec%0d_valE", i),    W_valE,    tbl[i].e_vale);
            chk($sformatf("vec%0d_dstE", i),    W_dstE,    tbl[i].e_dste);
            chk($sformatf("vec%0d_dstM", i),    W_dstM,    tbl[i].e_dstm);
            chk($sformatf("vec%0d_prog", i),    prog_stat, tbl[i].e_prog);
            chk($sformatf("vec%0d_halted", i),  halted,    tbl[i].e_halt);
            chk($sformatf("vec%0d_retired", i), retired,   tbl[i].e_ret);
            chk($sformatf("vec%0d_cycles", i),  cycles,    tbl[i].e_cyc);
        end

        // Three-cycle stall with stall+bubble and changing M inputs.
        drive(1'b1, 1'b0, 1'b0, 4'h1, 4'h2, 64'h0, 64'h0, 4'hF, 4'hF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 64'h55, 64'h66, 4'h1, 4'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'h1, 4'h6, 64'hA0 + 64'(i), 64'h1, 4'h7, 4'h8);
            tick();
        end
        chk("stall_valE",    W_valE,  64'h55);
        chk("stall_valM",    W_valM,  64'h66);
        chk("stall_icode",   W_icode, 4'h2);
        chk("stall_dstE",    W_dstE,  4'h1);
        chk("stall_retired", retired, 64'd1);
        chk("stall_cycles",  cycles,  64'd4);

        // Sixteen AOK loads wrap the 4-bit retire counter; then reset mid-run.
        drive(1'b1, 1'b0, 1'b0, 4'h1, 4'h3, 64'h0, 64'h0, 4'h0, 4'hF);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h1, 4'h3, 64'(i), 64'h0, 4'(i % 15), 4'hF);
            tick();
        end
        chk("wrap_ret4",    w4_retired, 4'd0);
        chk("wrap_cyc4",    w4_cycles,  4'd0);
        chk("wrap_ret64",   retired,    64'd16);
        chk("wrap_valE",    W_valE,     64'd15);
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_ret4_b",  w4_retired, 4'd3);
        drive(1'b1, 1'b1, 1'b0, 4'h1, 4'h3, 64'h5, 64'h0, 4'h0, 4'hF);
        tick();
        chk("rst_ret64",    retired,    64'd0);
        chk("rst_cyc64",    cycles,     64'd0);
        chk("rst_ret4",     w4_retired, 4'd0);
        chk("rst_cyc4",     w4_cycles,  4'd0);
        chk("rst_stat",     W_stat,     4'h0);

        // Randomized traffic against the reference model.
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] st;
            logic [3:0] de;
            logic [3:0] dm;
            case ($urandom_range(0, 39))
                0:       st = 4'h2;
                1:       st = 4'h3;
                2:       st = 4'h4;
                3, 4:    st = 4'h0;
                default: st = 4'h1;
            endcase
            de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 59) == 0) || (i == 0),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  st, 4'($urandom_range(0, 11)),
                  {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
            model_edge();
            tick();
            model_compare();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
